// File: rtl/doppler_settings_regfile.sv
// Double-buffered settings register file: host writes a shadow bank, which is
// copied atomically into the active bank on FRAME_SYNC or on an immediate CTRL commit.
module doppler_settings_regfile #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned N_TX        = 2,
  parameter int unsigned ACTIVE_BASE = 8
) (
  input  logic              MEM_CLK,
  input  logic              MEM_RST_N,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_WE,
  input  logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_RD,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_RVALID,
  output logic              ADDR_ERR,
  input  logic              FRAME_SYNC,
  output logic              COMMIT_PEND,
  output logic              ENABLE,
  output logic              RX_ON,
  output logic [N_TX-1:0]   TX_ON,
  output logic [1:0]        FREQUENCY,
  output logic [7:0]        GATE_LENGTH,
  output logic [15:0]       STATE0VALUE,
  output logic [15:0]       STATE1VALUE,
  output logic [15:0]       STATE2VALUE,
  output logic [15:0]       STATERVALUE
);

  localparam int unsigned NREG      = 5;
  localparam int unsigned CTRL_ADDR = 5;
  localparam int unsigned SET_IDX   = 4;

  logic [DATA_W-1:0] shadow_q [NREG];
  logic [DATA_W-1:0] shadow_d [NREG];
  logic [DATA_W-1:0] active_q [NREG];
  logic [DATA_W-1:0] active_d [NREG];
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q;
  logic              err_q, err_d;

  logic [31:0]       addr;
  logic              ctrl_wr;
  logic              commit;
  logic              rd_hit;
  logic              wr_hit;
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    addr    = 32'(MEM_ADDR);
    ctrl_wr = MEM_WE && (addr == CTRL_ADDR);
    commit  = (FRAME_SYNC && pend_q) || (ctrl_wr && MEM_WDATA[1]);

    // A commit consumes the pending flag, but a CTRL write on the same edge re-arms it.
    pend_d = pend_q;
    if (FRAME_SYNC && pend_q) pend_d = 1'b0;
    if (ctrl_wr) begin
      if (MEM_WDATA[1])      pend_d = 1'b0;
      else if (MEM_WDATA[0]) pend_d = 1'b1;
    end

    rd_word = '0;
    rd_hit  = (addr == CTRL_ADDR);
    wr_hit  = (addr == CTRL_ADDR);
    if (addr == CTRL_ADDR) rd_word[0] = pend_q;

    for (int unsigned i = 0; i < NREG; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = commit ? shadow_q[i] : active_q[i];
      if (addr == i) begin
        rd_word = shadow_q[i];
        rd_hit  = 1'b1;
        wr_hit  = 1'b1;
        if (MEM_WE) shadow_d[i] = MEM_WDATA;
      end
      if (addr == ACTIVE_BASE + i) begin
        rd_word = active_q[i];
        rd_hit  = 1'b1;
      end
    end

    err_d   = (MEM_WE && !wr_hit) || (MEM_RD && !rd_hit);
    rdata_d = MEM_RD ? rd_word : rdata_q;
  end

  always_ff @(posedge MEM_CLK or negedge MEM_RST_N) begin
    if (!MEM_RST_N) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      pend_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
      pend_q   <= pend_d;
      rdata_q  <= rdata_d;
      rvalid_q <= MEM_RD;
      err_q    <= err_d;
    end
  end

  assign MEM_RDATA   = rdata_q;
  assign MEM_RVALID  = rvalid_q;
  assign ADDR_ERR    = err_q;
  assign COMMIT_PEND = pend_q;

  assign TX_ON       = {N_TX{active_q[SET_IDX][0]}};
  assign RX_ON       = ~active_q[SET_IDX][1];
  assign ENABLE      = active_q[SET_IDX][2];
  assign GATE_LENGTH = active_q[SET_IDX][13:6];
  assign FREQUENCY   = active_q[SET_IDX][15:14];

  assign STATE0VALUE = active_q[0][15:0];
  assign STATE1VALUE = active_q[1][15:0];
  assign STATE2VALUE = active_q[2][15:0];
  assign STATERVALUE = active_q[3][15:0];

endmodule

// File: tb/tb_doppler_settings_regfile.sv
// Directed table-driven bench for doppler_settings_regfile (default parameters).
module tb_doppler_settings_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  addr;
  logic        we, rd, fs;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rvalid, aerr, pend;
  logic        enable, rx_on;
  logic [1:0]  tx_on, freq;
  logic [7:0]  gate;
  logic [15:0] s0, s1, s2, sr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  doppler_settings_regfile #(
    .DATA_W(16), .ADDR_W(4), .N_TX(2), .ACTIVE_BASE(8)
  ) dut (
    .MEM_CLK(clk), .MEM_RST_N(rst_n), .MEM_ADDR(addr), .MEM_WE(we),
    .MEM_WDATA(wdata), .MEM_RD(rd), .MEM_RDATA(rdata), .MEM_RVALID(rvalid),
    .ADDR_ERR(aerr), .FRAME_SYNC(fs), .COMMIT_PEND(pend), .ENABLE(enable),
    .RX_ON(rx_on), .TX_ON(tx_on), .FREQUENCY(freq), .GATE_LENGTH(gate),
    .STATE0VALUE(s0), .STATE1VALUE(s1), .STATE2VALUE(s2), .STATERVALUE(sr)
  );

  // Decoded outputs packed as {FREQUENCY, GATE_LENGTH, ENABLE, RX_ON, TX_ON}
  localparam logic [12:0] D0 = {2'b00, 8'h00, 1'b0, 1'b1, 2'b00};
  localparam logic [12:0] D1 = {2'b10, 8'h7E, 1'b1, 1'b0, 2'b11};

  typedef struct {
    logic        we, rd;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic        fs;
    logic [15:0] rdata;
    logic        rvalid, err, pend;
    logic [12:0] dec;
    logic [15:0] s0, s1;
    logic        chk_st;
  } vec_t;

  vec_t v [29];

  function automatic vec_t mk(input logic we_, rd_, input logic [3:0] a,
                              input logic [15:0] wd, input logic fs_,
                              input logic [15:0] rdv, input logic rvv, erv, pdv,
                              input logic [12:0] dv, input logic [15:0] s0v, s1v,
                              input logic cs);
    vec_t r;
    r.we = we_; r.rd = rd_; r.addr = a; r.wdata = wd; r.fs = fs_;
    r.rdata = rdv; r.rvalid = rvv; r.err = erv; r.pend = pdv;
    r.dec = dv; r.s0 = s0v; r.s1 = s1v; r.chk_st = cs;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [12:0] dec_now();
    return {freq, gate, enable, rx_on, tx_on};
  endfunction

  initial begin
    rst_n = 1'b0; addr = '0; we = 1'b0; rd = 1'b0; fs = 1'b0; wdata = '0;

    //        we rd addr wdata   fs  rdata   rv er pd dec s0       s1       chk
    v[0]  = mk(0, 1, 4,  16'h0,    0, 16'h0000, 1, 0, 0, D0, 16'h0000, 16'h0000, 1);
    v[1]  = mk(0, 1, 12, 16'h0,    0, 16'h0000, 1, 0, 0, D0, 16'h0000, 16'h0000, 1);
    v[2]  = mk(1, 0, 4,  16'h9F87, 0, 16'h0000, 0, 0, 0, D0, 16'h0000, 16'h0000, 1);
    v[3]  = mk(0, 1, 4,  16'h0,    0, 16'h9F87, 1, 0, 0, D0, 16'h0000, 16'h0000, 1);
    v[4]  = mk(0, 1, 12, 16'h0,    0, 16'h0000, 1, 0, 0, D0, 16'h0000, 16'h0000, 1);
    v[5]  = mk(1, 0, 5,  16'h0001, 0, 16'h0000, 0, 0, 1, D0, 16'h0000, 16'h0000, 1);
    v[6]  = mk(0, 1, 5,  16'h0,    0, 16'h0001, 1, 0, 1, D0, 16'h0000, 16'h0000, 1);
    v[7]  = mk(0, 0, 0,  16'h0,    1, 16'h0001, 0, 0, 0, D1, 16'h0000, 16'h0000, 1);
    v[8]  = mk(1, 0, 0,  16'h0010, 0, 16'h0001, 0, 0, 0, D1, 16'h0000, 16'h0000, 1);
    v[9]  = mk(0, 0, 0,  16'h0,    1, 16'h0001, 0, 0, 0, D1, 16'h0000, 16'h0000, 1);
    v[10] = mk(1, 0, 5,  16'h0001, 0, 16'h0001, 0, 0, 1, D1, 16'h0000, 16'h0000, 1);
    v[11] = mk(1, 0, 0,  16'h1234, 1, 16'h0001, 0, 0, 0, D1, 16'h0010, 16'h0000, 1);
    v[12] = mk(0, 1, 0,  16'h0,    0, 16'h1234, 1, 0, 0, D1, 16'h0010, 16'h0000, 1);
    v[13] = mk(0, 1, 8,  16'h0,    0, 16'h0010, 1, 0, 0, D1, 16'h0010, 16'h0000, 1);
    v[14] = mk(1, 0, 5,  16'h0001, 1, 16'h0010, 0, 0, 1, D1, 16'h0010, 16'h0000, 1);
    v[15] = mk(0, 0, 0,  16'h0,    1, 16'h0010, 0, 0, 0, D1, 16'h1234, 16'h0000, 1);
    v[16] = mk(1, 0, 1,  16'h00FF, 0, 16'h0010, 0, 0, 0, D1, 16'h1234, 16'h0000, 1);
    v[17] = mk(1, 0, 5,  16'h0002, 0, 16'h0010, 0, 0, 0, D1, 16'h1234, 16'h00FF, 0);
    v[18] = mk(0, 0, 0,  16'h0,    0, 16'h0010, 0, 0, 0, D1, 16'h1234, 16'h00FF, 1);
    v[19] = mk(1, 0, 6,  16'hAAAA, 0, 16'h0010, 0, 1, 0, D1, 16'h1234, 16'h00FF, 1);
    v[20] = mk(1, 0, 9,  16'h5555, 0, 16'h0010, 0, 1, 0, D1, 16'h1234, 16'h00FF, 1);
    v[21] = mk(0, 1, 15, 16'h0,    0, 16'h0000, 1, 1, 0, D1, 16'h1234, 16'h00FF, 1);
    v[22] = mk(0, 1, 9,  16'h0,    0, 16'h00FF, 1, 0, 0, D1, 16'h1234, 16'h00FF, 1);
    v[23] = mk(1, 1, 2,  16'hBEEF, 0, 16'h0000, 1, 0, 0, D1, 16'h1234, 16'h00FF, 1);
    v[24] = mk(0, 1, 2,  16'h0,    0, 16'hBEEF, 1, 0, 0, D1, 16'h1234, 16'h00FF, 1);
    v[25] = mk(0, 1, 10, 16'h0,    0, 16'h0000, 1, 0, 0, D1, 16'h1234, 16'h00FF, 1);
    v[26] = mk(1, 0, 5,  16'h0001, 0, 16'h0000, 0, 0, 1, D1, 16'h1234, 16'h00FF, 1);
    v[27] = mk(1, 0, 5,  16'h0002, 0, 16'h0000, 0, 0, 0, D1, 16'h1234, 16'h00FF, 0);
    v[28] = mk(0, 1, 10, 16'h0,    0, 16'hBEEF, 1, 0, 0, D1, 16'h1234, 16'h00FF, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_err", 32'(aerr), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_dec", 32'(dec_now()), 32'(D0));
    check("rst_s0", 32'(s0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      we = v[i].we; rd = v[i].rd; addr = v[i].addr; wdata = v[i].wdata; fs = v[i].fs;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(v[i].rdata));
      check($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(v[i].rvalid));
      check($sformatf("v%0d_err", i), 32'(aerr), 32'(v[i].err));
      check($sformatf("v%0d_pend", i), 32'(pend), 32'(v[i].pend));
      check($sformatf("v%0d_dec", i), 32'(dec_now()), 32'(v[i].dec));
      if (v[i].chk_st) begin
        check($sformatf("v%0d_s0", i), 32'(s0), 32'(v[i].s0));
        check($sformatf("v%0d_s1", i), 32'(s1), 32'(v[i].s1));
      end
    end

    @(negedge clk);
    we = 1'b0; rd = 1'b0; fs = 1'b0;
    @(posedge clk);
    #1;
    check("imm_s2", 32'(s2), 32'hBEEF);
    check("imm_sr", 32'(sr), 32'h0);

    // Reset while a commit is pending
    @(negedge clk);
    we = 1'b1; addr = 4'd5; wdata = 16'h0001;
    @(posedge clk);
    #1;
    check("prerst_pend", 32'(pend), 32'h1);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_pend", 32'(pend), 32'h0);
    check("async_dec", 32'(dec_now()), 32'(D0));
    check("async_s0", 32'(s0), 32'h0);
    check("async_s1", 32'(s1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fs = 1'b1;
    @(posedge clk);
    #1;
    check("postrst_pend", 32'(pend), 32'h0);
    check("postrst_dec", 32'(dec_now()), 32'(D0));
    check("postrst_s0", 32'(s0), 32'h0);
    @(negedge clk);
    fs = 1'b0; rd = 1'b1; addr = 4'd0;
    @(posedge clk);
    #1;
    check("postrst_shadow0", 32'(rdata), 32'h0);
    @(negedge clk);
    rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
